// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle shared by the fabric master and register-bank responders.
// Address/data widths must match the responder attached to the slave modport.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [2:0]                AWPROT;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic [2:0]                ARPROT;
  logic                      RVALID;
  logic                      RREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank with byte strobes; B/R valid one cycle after the completing handshake.
// Responses are held until BREADY/RREADY; a channel's READYs stay low while its response is pending.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_if.slave                      S_AXI_LITE,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;
  logic [IDX_W-1:0]      cm_idx, ar_idx;
  logic                  cm_in_range, ar_in_range;
  logic                  unused_prot;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> LSB) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  // READYs decode the idle-ish states directly, so they must be forced low during reset.
  assign aw_rdy = ~ARESET & ((w_state == W_IDLE) || (w_state == W_HAVE_DATA));
  assign w_rdy  = ~ARESET & ((w_state == W_IDLE) || (w_state == W_HAVE_ADDR));
  assign ar_rdy = ~ARESET & (r_state == R_IDLE);
  assign aw_hs  = S_AXI_LITE.AWVALID & aw_rdy;
  assign w_hs   = S_AXI_LITE.WVALID & w_rdy;
  assign ar_hs  = S_AXI_LITE.ARVALID & ar_rdy;

  assign S_AXI_LITE.AWREADY = aw_rdy;
  assign S_AXI_LITE.WREADY  = w_rdy;
  assign S_AXI_LITE.ARREADY = ar_rdy;
  assign S_AXI_LITE.BVALID  = bvalid_q;
  assign S_AXI_LITE.BRESP   = bresp_q;
  assign S_AXI_LITE.RVALID  = rvalid_q;
  assign S_AXI_LITE.RDATA   = rdata_q;
  assign S_AXI_LITE.RRESP   = rresp_q;
  assign reg_out            = regs;
  assign unused_prot        = ^{S_AXI_LITE.AWPROT, S_AXI_LITE.ARPROT};

  assign cm_idx      = cm_addr[LSB +: IDX_W];
  assign cm_in_range = addr_in_range(cm_addr);
  assign ar_idx      = S_AXI_LITE.ARADDR[LSB +: IDX_W];
  assign ar_in_range = addr_in_range(S_AXI_LITE.ARADDR);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Commit operands come from the live bus for whichever half arrives last.
  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    cm_addr     = aw_addr_q;
    cm_data     = w_data_q;
    cm_strb     = w_strb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          cm_addr     = S_AXI_LITE.AWADDR;
          cm_data     = S_AXI_LITE.WDATA;
          cm_strb     = S_AXI_LITE.WSTRB;
          w_state_nxt = W_RESP;
        end else if (aw_hs) begin
          w_state_nxt = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_state_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          commit      = 1'b1;
          cm_data     = S_AXI_LITE.WDATA;
          cm_strb     = S_AXI_LITE.WSTRB;
          w_state_nxt = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          commit      = 1'b1;
          cm_addr     = S_AXI_LITE.AWADDR;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_LITE.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_LITE.RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs      <= '0;
      wr_pulse  <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) aw_addr_q <= S_AXI_LITE.AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_LITE.WDATA;
        w_strb_q <= S_AXI_LITE.WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        if (cm_in_range) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (cm_strb[k]) regs[cm_idx][8*k +: 8] <= cm_data[8*k +: 8];
          end
          wr_pulse[cm_idx] <= 1'b1;
          bresp_q          <= RESP_OKAY;
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end else if (bvalid_q && S_AXI_LITE.BREADY) begin
        bvalid_q <= 1'b0;
      end
      // Non-blocking read of regs gives the pre-write value on a same-edge collision.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_in_range ? regs[ar_idx] : '0;
        rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_LITE.RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule
